// File: rtl/z80_bus_uart_pkg.sv
// Shared definitions for the Z80 bus UART: register offsets, STATUS bit
// positions and the state encoding used by both serial FSMs.
package z80_bus_uart_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;

  localparam int ST_TX_FULL  = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_RX_VALID = 2;
  localparam int ST_OVERRUN  = 3;
  localparam int ST_TX_BUSY  = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/z80_bus_uart_fifo.sv
// Synchronous first-word-fall-through FIFO. Pointers carry one extra wrap
// bit so full and empty can be told apart. A push while full is dropped,
// with full judged before any same-cycle pop.
module z80_bus_uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push_s, do_pop_s;

  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign do_push_s = push_i & ~full_o;
  assign do_pop_s  = pop_i & ~empty_o;
  assign data_o    = mem_q[rd_ptr_q[AW-1:0]];

  // Advance read/write pointers on accepted pop/push.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push_s) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop_s)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  // Storage array; contents are meaningless after reset since pointers clear.
  always_ff @(posedge clk) begin
    if (do_push_s) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/z80_bus_uart.sv
// Memory-mapped 8N1 UART on the Z80 bus. CPU writes to DATA are queued in a
// TX FIFO and serialised; one received byte is held for the CPU to read.
// Define UART_RX_EN to build the receiver, rx_valid/overrun and DATA reads.
module z80_bus_uart
  import z80_bus_uart_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cs,
  input  logic [1:0] addr,
  input  logic [7:0] d_in,
  output logic [7:0] d_out,
  input  logic       oe,
  input  logic       we,
  output logic       tx,
  input  logic       rx
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic        oe_q, we_q, cs_q;
  logic [1:0]  addr_q;
  logic        wr_evt_s, pop_evt_s, push_s;
  logic        fifo_full_s, fifo_empty_s, tx_pop_s;
  logic [7:0]  fifo_data_s;
  uart_state_e tx_state_q;
  logic [CW-1:0] tx_cnt_q;
  logic [2:0]  tx_bit_q;
  logic [7:0]  tx_shift_q;
  logic        tx_q;
  logic        rx_valid_s, overrun_s;
  logic [7:0]  rx_data_s, status_s;

  assign wr_evt_s  = cs & we & ~we_q;
  assign pop_evt_s = oe_q & ~oe & cs_q & (addr_q == REG_DATA);
  assign push_s    = wr_evt_s & (addr == REG_DATA);
  assign tx_pop_s  = ~fifo_empty_s &
                     ((tx_state_q == S_IDLE) ||
                      ((tx_state_q == S_STOP) && (tx_cnt_q == CNT_MAX)));
  assign tx        = tx_q;

  // Strobe history for edge detection; cs/addr held from the read strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      oe_q   <= 1'b0;
      we_q   <= 1'b0;
      cs_q   <= 1'b0;
      addr_q <= 2'd0;
    end else begin
      oe_q <= oe;
      we_q <= we;
      if (oe) begin
        cs_q   <= cs;
        addr_q <= addr;
      end
    end
  end

  z80_bus_uart_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_txfifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (push_s),
    .pop_i   (tx_pop_s),
    .data_i  (d_in),
    .data_o  (fifo_data_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  // TX FSM: start bit, 8 data bits LSB first, stop bit; back-to-back frames.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= 3'd0;
      tx_shift_q <= 8'h00;
      tx_q       <= 1'b1;
    end else begin
      case (tx_state_q)
        S_IDLE: begin
          tx_cnt_q <= '0;
          if (!fifo_empty_s) begin
            tx_shift_q <= fifo_data_s;
            tx_q       <= 1'b0;
            tx_state_q <= S_START;
          end
        end
        S_START: begin
          if (tx_cnt_q == CNT_MAX) begin
            tx_cnt_q   <= '0;
            tx_bit_q   <= 3'd0;
            tx_q       <= tx_shift_q[0];
            tx_shift_q <= {1'b0, tx_shift_q[7:1]};
            tx_state_q <= S_DATA;
          end else begin
            tx_cnt_q <= tx_cnt_q + CNT_ONE;
          end
        end
        S_DATA: begin
          if (tx_cnt_q == CNT_MAX) begin
            tx_cnt_q <= '0;
            if (tx_bit_q == 3'd7) begin
              tx_q       <= 1'b1;
              tx_state_q <= S_STOP;
            end else begin
              tx_q       <= tx_shift_q[0];
              tx_shift_q <= {1'b0, tx_shift_q[7:1]};
              tx_bit_q   <= tx_bit_q + 3'd1;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + CNT_ONE;
          end
        end
        S_STOP: begin
          if (tx_cnt_q == CNT_MAX) begin
            tx_cnt_q <= '0;
            if (!fifo_empty_s) begin
              tx_shift_q <= fifo_data_s;
              tx_q       <= 1'b0;
              tx_state_q <= S_START;
            end else begin
              tx_state_q <= S_IDLE;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + CNT_ONE;
          end
        end
        default: begin
          tx_state_q <= S_IDLE;
          tx_q       <= 1'b1;
        end
      endcase
    end
  end

`ifdef UART_RX_EN
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  logic        rx_s1_q, rx_s2_q, rx_prev_q;
  uart_state_e rx_state_q;
  logic [CW-1:0] rx_cnt_q;
  logic [2:0]  rx_bit_q;
  logic [7:0]  rx_shift_q, rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d, overrun_q, overrun_d;
  logic        rx_done_s, load_s, ovr_set_s, ovr_clr_s;

  assign rx_done_s  = (rx_state_q == S_STOP) && (rx_cnt_q == CNT_MAX) && rx_s2_q;
  assign load_s     = rx_done_s & (~rx_valid_q | pop_evt_s);
  assign ovr_set_s  = rx_done_s & rx_valid_q & ~pop_evt_s;
  assign ovr_clr_s  = wr_evt_s & (addr == REG_STATUS) & d_in[3];
  assign rx_data_d  = load_s ? rx_shift_q : rx_data_q;
  assign rx_valid_d = load_s ? 1'b1 : (pop_evt_s ? 1'b0 : rx_valid_q);
  assign overrun_d  = ovr_set_s ? 1'b1 : (ovr_clr_s ? 1'b0 : overrun_q);
  assign rx_valid_s = rx_valid_q;
  assign overrun_s  = overrun_q;
  assign rx_data_s  = rx_data_q;

  // Two-flop synchroniser plus one history flop for falling-edge detect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  // RX FSM: validate start at half bit, then sample data and stop mid-bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= 3'd0;
      rx_shift_q <= 8'h00;
    end else begin
      case (rx_state_q)
        S_IDLE: begin
          rx_cnt_q <= '0;
          if (rx_prev_q & ~rx_s2_q) rx_state_q <= S_START;
        end
        S_START: begin
          if (rx_cnt_q == CNT_HALF) begin
            rx_cnt_q   <= '0;
            rx_bit_q   <= 3'd0;
            rx_state_q <= rx_s2_q ? S_IDLE : S_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + CNT_ONE;
          end
        end
        S_DATA: begin
          if (rx_cnt_q == CNT_MAX) begin
            rx_cnt_q   <= '0;
            rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
            if (rx_bit_q == 3'd7) rx_state_q <= S_STOP;
            else                  rx_bit_q   <= rx_bit_q + 3'd1;
          end else begin
            rx_cnt_q <= rx_cnt_q + CNT_ONE;
          end
        end
        S_STOP: begin
          if (rx_cnt_q == CNT_MAX) begin
            rx_cnt_q   <= '0;
            rx_state_q <= S_IDLE;
          end else begin
            rx_cnt_q <= rx_cnt_q + CNT_ONE;
          end
        end
        default: rx_state_q <= S_IDLE;
      endcase
    end
  end

  // Holding register with rx_valid and sticky overrun flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      overrun_q  <= overrun_d;
    end
  end
`else
  logic unused_rx_s;
  assign unused_rx_s = rx ^ pop_evt_s;
  assign rx_valid_s  = 1'b0;
  assign overrun_s   = 1'b0;
  assign rx_data_s   = 8'h00;
`endif

  // STATUS register assembly.
  always_comb begin
    status_s              = 8'h00;
    status_s[ST_TX_FULL]  = fifo_full_s;
    status_s[ST_TX_EMPTY] = fifo_empty_s & (tx_state_q == S_IDLE);
    status_s[ST_RX_VALID] = rx_valid_s;
    status_s[ST_OVERRUN]  = overrun_s;
    status_s[ST_TX_BUSY]  = (tx_state_q != S_IDLE);
  end

  // Read-data mux, forced to zero outside the read strobe.
  always_comb begin
    d_out = 8'h00;
    if (oe) begin
      case (addr)
        REG_DATA:   d_out = rx_data_s;
        REG_STATUS: d_out = status_s;
        default:    d_out = 8'h00;
      endcase
    end else begin
      d_out = 8'h00;
    end
  end

endmodule
